// File: rtl/vector_lsu_if.sv
// Bundle of the load/store sequencer's request, store-data, load-data,
// status and memory-port signals.
// master: the requester side, which also owns the memory read-data return.
// slave : the vector_lsu itself.
interface vector_lsu_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 512
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_beats;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              err;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_input_data;
  logic [DATA_W-1:0] mem_output_data;

  modport master (
    output req_valid, req_write, req_addr, req_beats, wdata_valid, wdata,
           rdata_ready, mem_output_data,
    input  req_ready, wdata_ready, rdata_valid, rdata, busy, err,
           mem_address, mem_write_enable, mem_input_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_beats, wdata_valid, wdata,
           rdata_ready, mem_output_data,
    output req_ready, wdata_ready, rdata_valid, rdata, busy, err,
           mem_address, mem_write_enable, mem_input_data
  );
endinterface

// File: rtl/vector_lsu.sv
// vector_lsu: burst load/store sequencer in front of the 512x32b vector
// data memory. Moves 1-4 consecutive 16-word beats per request. Beat
// addresses step by BEAT_WORDS and wrap modulo the memory size.
// Optional feature macro: LSU_BOUNDS_CHECK_EN rejects bursts that would
// run past the top of memory and pulses err for one cycle.
module vector_lsu #(
  parameter int BEAT_WORDS = 16,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 512
) (
  input  logic          clk,
  input  logic          reset,
  vector_lsu_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RD, RD_WAIT, WR} state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BEAT_WORDS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        beats_left;
  logic [DATA_W-1:0] rdata_q;
  logic              rdata_valid_q;
  logic              accept;
  logic              reject;
  logic              last_beat;

  assign accept    = bus.req_valid & (state == IDLE);
  assign last_beat = (beats_left == 2'd0);

`ifdef LSU_BOUNDS_CHECK_EN
  // Two spare bits hold the end address of a maximal burst without overflow.
  localparam int SPAN_W = ADDR_W + 2;
  logic [SPAN_W-1:0] span_end;
  logic              err_q;

  assign span_end = SPAN_W'(bus.req_addr)
                  + SPAN_W'(BEAT_WORDS) * (SPAN_W'(bus.req_beats) + SPAN_W'(1));
  assign reject   = span_end > SPAN_W'(1 << ADDR_W);

  // err is a single-cycle pulse following a rejected accept.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= accept & reject;
  end
  assign bus.err = err_q;
`else
  assign reject  = 1'b0;
  assign bus.err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake/memory strobes; write enable is gated by reset
  // so an abandoned burst cannot write during the reset cycle.
  always_comb begin
    state_nxt            = state;
    bus.req_ready        = 1'b0;
    bus.wdata_ready      = 1'b0;
    bus.mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept && !reject) state_nxt = bus.req_write ? WR : RD;
      end
      RD:      state_nxt = RD_WAIT;
      RD_WAIT: if (bus.rdata_ready) state_nxt = last_beat ? IDLE : RD;
      WR: begin
        bus.wdata_ready      = 1'b1;
        bus.mem_write_enable = bus.wdata_valid & ~reset;
        if (bus.wdata_valid && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Burst address/count tracking and the registered load beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_addr      <= '0;
      beats_left    <= 2'd0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cur_addr   <= bus.req_addr;
            beats_left <= bus.req_beats;
          end
        end
        RD: begin
          rdata_q       <= bus.mem_output_data;
          rdata_valid_q <= 1'b1;
        end
        RD_WAIT: begin
          if (bus.rdata_ready) begin
            rdata_valid_q <= 1'b0;
            if (!last_beat) begin
              cur_addr   <= cur_addr + ADDR_STEP;
              beats_left <= beats_left - 2'd1;
            end
          end
        end
        WR: begin
          if (bus.wdata_valid && !last_beat) begin
            cur_addr   <= cur_addr + ADDR_STEP;
            beats_left <= beats_left - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rdata          = rdata_q;
  assign bus.rdata_valid    = rdata_valid_q;
  assign bus.busy           = (state != IDLE);
  assign bus.mem_address    = cur_addr;
  assign bus.mem_input_data = bus.wdata;

endmodule
